// File: rtl/beat_sum_accumulator_pkg.sv
// Shared definitions for the adder-family blocks: FSM state encodings and
// the accumulator width helper.
package beat_sum_accumulator_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ACCUM = 2'd1;
    localparam logic [1:0] ST_HOLD  = 2'd2;

    // Width that holds the sum of `beats` unsigned n-bit operands without overflow.
    function automatic int acc_width(input int n, input int beats);
        return n + $clog2(beats);
    endfunction

endpackage

// File: rtl/beat_sum_accumulator_adder.sv
// Purpose: n-bit ripple-carry adder, carry-in tied low; sum_o[n] is the carry-out.
// Latency: combinational. Backpressure: none.
module nBitRippleCarryAdder #(
    parameter int n = 8
) (
    input  logic [n-1:0] a_i,
    input  logic [n-1:0] b_i,
    output logic [n:0]   sum_o
);

    logic [n:0] carry;

    assign carry[0] = 1'b0;

    // Bit 0 degenerates to a half adder because carry[0] is constant zero.
    for (genvar i = 0; i < n; i++) begin : g_fa
        assign sum_o[i]    = a_i[i] ^ b_i[i] ^ carry[i];
        assign carry[i+1]  = (a_i[i] & b_i[i]) | (carry[i] & (a_i[i] ^ b_i[i]));
    end

    assign sum_o[n] = carry[n];

endmodule

// File: rtl/beat_sum_accumulator.sv
// Purpose: sums each group of BEATS unsigned operands, one beat per cycle, through one adder.
// Latency: result valid the cycle after the last beat; backpressure holds result, deasserts inReady.
module beat_sum_accumulator
    import beat_sum_accumulator_pkg::*;
#(
    parameter  int N     = 8,
    parameter  int BEATS = 4,
    localparam int ACC_W = acc_width(N, BEATS)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             inValid,
    output logic             inReady,
    input  logic [N-1:0]     inData,
    output logic             outValid,
    input  logic             outReady,
    output logic [ACC_W-1:0] outSum,
    output logic             busy
);

    localparam int              CNT_W = $clog2(BEATS + 1);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(BEATS - 1);

    logic [1:0]       state_q, state_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             out_vld_q, out_vld_d;
    logic [ACC_W-1:0] out_sum_q, out_sum_d;

    logic [ACC_W-1:0] add_a;
    logic [ACC_W-1:0] add_b;
    logic [ACC_W:0]   add_sum;
    logic             carry_unused;
    logic             in_acc;

    assign inReady  = (state_q != ST_HOLD) && !clear;
    assign in_acc   = inValid && inReady;
    assign outValid = out_vld_q;
    assign outSum   = out_sum_q;
    assign busy     = (state_q == ST_ACCUM);

    // A group always starts from zero, independent of whatever acc holds in IDLE.
    assign add_a = (state_q == ST_ACCUM) ? acc_q : '0;
    assign add_b = {{(ACC_W - N){1'b0}}, inData};

    nBitRippleCarryAdder #(.n(ACC_W)) u_adder (
        .a_i   (add_a),
        .b_i   (add_b),
        .sum_o (add_sum)
    );

    // ACC_W is sized so this carry can never be set.
    assign carry_unused = add_sum[ACC_W];

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        out_vld_d = out_vld_q;
        out_sum_d = out_sum_q;
        case (state_q)
            ST_IDLE, ST_ACCUM: begin
                if (clear) begin
                    state_d = ST_IDLE;
                    acc_d   = '0;
                    cnt_d   = '0;
                end else if (in_acc) begin
                    acc_d = add_sum[ACC_W-1:0];
                    cnt_d = cnt_q + CNT_W'(1);
                    if (state_q == ST_ACCUM && cnt_q == LAST) begin
                        out_sum_d = add_sum[ACC_W-1:0];
                        out_vld_d = 1'b1;
                        state_d   = ST_HOLD;
                    end else begin
                        state_d = ST_ACCUM;
                    end
                end
            end
            ST_HOLD: begin
                if (out_vld_q && outReady) begin
                    out_vld_d = 1'b0;
                    acc_d     = '0;
                    cnt_d     = '0;
                    state_d   = ST_IDLE;
                end
            end
            default: begin
                state_d   = ST_IDLE;
                acc_d     = '0;
                cnt_d     = '0;
                out_vld_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            acc_q     <= '0;
            cnt_q     <= '0;
            out_vld_q <= 1'b0;
            out_sum_q <= '0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            out_vld_q <= out_vld_d;
            out_sum_q <= out_sum_d;
        end
    end

endmodule

// File: tb/tb_beat_sum_accumulator.sv
// Directed bench for beat_sum_accumulator (N=8, BEATS=4) with hand-computed sums.
module tb_beat_sum_accumulator;

    localparam int N     = 8;
    localparam int BEATS = 4;
    localparam int ACC_W = 10;

    logic             clk = 1'b0;
    logic             reset;
    logic             clear;
    logic             inValid;
    logic             inReady;
    logic [N-1:0]     inData;
    logic             outValid;
    logic             outReady;
    logic [ACC_W-1:0] outSum;
    logic             busy;

    int tests_run    = 0;
    int tests_failed = 0;
    int carry_errs   = 0;

    beat_sum_accumulator #(.N(N), .BEATS(BEATS)) dut (
        .clk      (clk),
        .reset    (reset),
        .clear    (clear),
        .inValid  (inValid),
        .inReady  (inReady),
        .inData   (inData),
        .outValid (outValid),
        .outReady (outReady),
        .outSum   (outSum),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (!reset && dut.add_sum[ACC_W] !== 1'b0) carry_errs++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Offer one beat and wait (bounded) until it is taken.
    task automatic send(input logic [N-1:0] d);
        int n;
        n       = 0;
        inValid = 1'b1;
        inData  = d;
        while (!inReady && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 50) check("send_timeout", 1, 0);
        @(posedge clk);
        #1;
        inValid = 1'b0;
    endtask

    task automatic send4(input logic [N-1:0] a, input logic [N-1:0] b,
                         input logic [N-1:0] c, input logic [N-1:0] d);
        send(a);
        send(b);
        send(c);
        send(d);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset    = 1'b1;
        clear    = 1'b0;
        inValid  = 1'b0;
        inData   = '0;
        outReady = 1'b1;

        // 1. reset state
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        check("rst_outValid", outValid, 0);
        check("rst_outSum",   outSum,   0);
        check("rst_busy",     busy,     0);
        check("rst_inReady",  inReady,  1);

        // 2. 1+2+3+4, back-to-back, sink always ready
        send(8'd1);
        check("t2_busy_mid", busy, 1);
        send(8'd2);
        send(8'd3);
        send(8'd4);
        check("t2_outValid", outValid, 1);
        check("t2_outSum",   outSum,   10);
        check("t2_inReady_hold", inReady, 0);
        check("t2_busy_hold", busy, 0);
        tick();
        check("t2_outValid_done", outValid, 0);
        check("t2_inReady_back",  inReady,  1);
        check("t2_outSum_kept",   outSum,   10);

        // 3. maximum operands
        send4(8'd255, 8'd255, 8'd255, 8'd255);
        check("t3_outValid", outValid, 1);
        check("t3_outSum",   outSum,   1020);
        tick();

        // 4. output backpressure
        outReady = 1'b0;
        send4(8'd7, 8'd7, 8'd7, 8'd7);
        check("t4_outValid", outValid, 1);
        check("t4_outSum",   outSum,   28);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("t4_hold_outValid", outValid, 1);
            check("t4_hold_outSum",   outSum,   28);
            check("t4_hold_inReady",  inReady,  0);
        end
        outReady = 1'b1;
        tick();
        check("t4_done_outValid", outValid, 0);
        check("t4_done_busy",     busy,     0);
        check("t4_done_inReady",  inReady,  1);
        check("t4_done_outSum",   outSum,   28);

        // 5. clear aborts partial group and blocks the beat offered with it
        send(8'd10);
        send(8'd20);
        clear   = 1'b1;
        inValid = 1'b1;
        inData  = 8'd99;
        #1;
        check("t5_inReady_clear", inReady, 0);
        tick();
        clear   = 1'b0;
        inValid = 1'b0;
        #1;
        check("t5_busy_after_clear", busy, 0);
        send4(8'd1, 8'd1, 8'd1, 8'd1);
        check("t5_outValid", outValid, 1);
        check("t5_outSum",   outSum,   4);
        tick();

        // 6. async reset mid-group
        send(8'd3);
        send(8'd3);
        send(8'd3);
        check("t6_busy_before", busy, 1);
        #2;
        reset = 1'b1;
        #1;
        check("t6_busy_reset",     busy,     0);
        check("t6_outValid_reset", outValid, 0);
        check("t6_outSum_reset",   outSum,   0);
        tick();
        reset = 1'b0;
        send4(8'd5, 8'd5, 8'd5, 8'd5);
        check("t6_outValid", outValid, 1);
        check("t6_outSum",   outSum,   20);
        tick();

        // 6b. same group with inValid gaps between beats
        for (int i = 0; i < 3; i++) begin
            send(8'd5);
            tick();
            tick();
            check("t6b_busy_gap",     busy,     1);
            check("t6b_outValid_gap", outValid, 0);
        end
        send(8'd5);
        check("t6b_outValid", outValid, 1);
        check("t6b_outSum",   outSum,   20);
        tick();
        check("t6b_done_outValid", outValid, 0);

        check("carry_out_zero", carry_errs, 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
